// File: rtl/lvds_frame_tx.sv
// Output framer: pops hit records from the hit memory and emits
// HEADER / DATA... / TRAILER frames on a 24-bit LVDS word bus, with a
// fixed idle pattern and a forced idle gap between frames. Single clock (clk3).
module lvds_frame_tx #(
   parameter int unsigned DATASIZE   = 18,
   parameter int unsigned MAX_HITS   = 4096,
   parameter int unsigned GAP_CYCLES = 2,
   parameter logic [23:0] IDLE_WORD  = 24'h0AAAAA
) (
   input  logic                clk3,
   input  logic                sys_reset,
   input  logic                tx_enable,
   input  logic                mem_empty,
   output logic                mem_rd_en,
   input  logic [DATASIZE-1:0] mem_data,
   output logic [23:0]         LVDS,
   output logic                lvds_valid,
   output logic [15:0]         frame_id,
   output logic                busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_GAP
   } state_t;

   localparam logic [12:0] MAX_HITS_C = 13'(MAX_HITS);
   localparam logic [3:0]  GAP_LAST   = 4'(GAP_CYCLES - 1);

   state_t      state_q, state_d;
   logic [23:0] lvds_q, lvds_d;
   logic        valid_q, valid_d;
   logic [15:0] frame_id_q, frame_id_d;
   logic [12:0] issued_q, issued_d;   // pops requested in this frame
   logic [12:0] cnt_q, cnt_d;         // DATA words emitted in this frame
   logic [8:0]  chk_q, chk_d;         // running XOR fold of emitted records
   logic [3:0]  gap_q, gap_d;         // idle words emitted since TRAILER
   logic        rd_pending_q;         // mem_data carries a record this cycle

   // Pop request: start-of-frame pop from IDLE, then keep popping while the
   // memory has data and the per-frame limit is not reached. Held low in reset.
   always_comb begin
      mem_rd_en = 1'b0;
      if (!sys_reset) begin
         if (state_q == S_IDLE) begin
            mem_rd_en = tx_enable & ~mem_empty;
         end else if (state_q == S_DATA) begin
            mem_rd_en = ~mem_empty & (issued_q < MAX_HITS_C);
         end
      end
   end

   // Next-state and output-word selection for the framing FSM.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d    = state_q;
      lvds_d     = lvds_q;
      valid_d    = valid_q;
      frame_id_d = frame_id_q;
      cnt_d      = cnt_q;
      chk_d      = chk_q;
      gap_d      = gap_q;
      issued_d   = issued_q + {12'd0, mem_rd_en};

      unique case (state_q)
         S_IDLE: begin
            lvds_d  = IDLE_WORD;
            valid_d = 1'b0;
            if (tx_enable && !mem_empty) begin
               lvds_d  = {2'b01, 6'b0, frame_id_q};
               valid_d = 1'b1;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (rd_pending_q) begin
               // seq is the low nibble of the word index, taken before increment
               lvds_d = {2'b10, cnt_q[3:0], mem_data};
               cnt_d  = cnt_q + 13'd1;
               chk_d  = chk_q ^ mem_data[17:9] ^ mem_data[8:0];
            end else begin
               // No record arrived: pops stopped, so close the frame here.
               lvds_d  = {2'b11, chk_q, cnt_q};
               gap_d   = 4'd0;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            lvds_d  = IDLE_WORD;
            valid_d = 1'b0;
            if (gap_q == 4'd0) begin
               frame_id_d = frame_id_q + 16'd1;
               cnt_d      = 13'd0;
               chk_d      = 9'd0;
               issued_d   = 13'd0;
            end
            gap_d = gap_q + 4'd1;
            if (gap_q == GAP_LAST) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any frame in progress.
   always_ff @(posedge clk3 or posedge sys_reset) begin
      if (sys_reset) begin
         state_q      <= S_IDLE;
         lvds_q       <= IDLE_WORD;
         valid_q      <= 1'b0;
         frame_id_q   <= 16'd0;
         issued_q     <= 13'd0;
         cnt_q        <= 13'd0;
         chk_q        <= 9'd0;
         gap_q        <= 4'd0;
         rd_pending_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state_q      <= state_d;
         lvds_q       <= lvds_d;
         valid_q      <= valid_d;
         frame_id_q   <= frame_id_d;
         issued_q     <= issued_d;
         cnt_q        <= cnt_d;
         chk_q        <= chk_d;
         gap_q        <= gap_d;
         rd_pending_q <= mem_rd_en;
      end
   end

   assign LVDS       = lvds_q;
   assign lvds_valid = valid_q;
   assign frame_id   = frame_id_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_lvds_frame_tx.sv
// Directed bench for lvds_frame_tx with a one-cycle-latency hit memory model.
module tb_lvds_frame_tx;

   localparam logic [23:0] IDLE_W = 24'h0AAAAA;

   logic        clk3 = 1'b0;
   logic        sys_reset;
   logic        tx_enable;
   logic        mem_empty;
   logic        mem_rd_en;
   logic [17:0] mem_data = '0;
   logic [23:0] LVDS;
   logic        lvds_valid;
   logic [15:0] frame_id;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   logic [17:0] mem_arr [256];
   int          wr_ptr = 0;
   int          rd_ptr = 0;

   lvds_frame_tx #(
      .DATASIZE   (18),
      .MAX_HITS   (4),
      .GAP_CYCLES (2),
      .IDLE_WORD  (24'h0AAAAA)
   ) dut (
      .clk3       (clk3),
      .sys_reset  (sys_reset),
      .tx_enable  (tx_enable),
      .mem_empty  (mem_empty),
      .mem_rd_en  (mem_rd_en),
      .mem_data   (mem_data),
      .LVDS       (LVDS),
      .lvds_valid (lvds_valid),
      .frame_id   (frame_id),
      .busy       (busy)
   );

   always #5 clk3 = ~clk3;

   // Hit memory: record appears on mem_data the cycle after an accepted pop.
   assign mem_empty = (rd_ptr >= wr_ptr);
   always @(posedge clk3) begin
      if (mem_rd_en) begin
         mem_data <= mem_arr[rd_ptr % 256];
         rd_ptr   <= rd_ptr + 1;
      end
   end

   task automatic push(input logic [17:0] d);
      mem_arr[wr_ptr % 256] = d;
      wr_ptr++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and compare the LVDS word and valid.
   task automatic step(input string tag, input logic [23:0] w, input logic v);
      @(negedge clk3);
      check({tag, "_lvds"}, 32'(LVDS), 32'(w));
      check({tag, "_valid"}, 32'(lvds_valid), 32'(v));
   endtask

   function automatic logic [23:0] hdr(input logic [15:0] id);
      return {2'b01, 6'b0, id};
   endfunction

   function automatic logic [23:0] dat(input logic [3:0] seq, input logic [17:0] d);
      return {2'b10, seq, d};
   endfunction

   function automatic logic [23:0] trl(input logic [8:0] c, input logic [12:0] n);
      return {2'b11, c, n};
   endfunction

   function automatic logic [8:0] fold(input logic [17:0] d);
      return d[17:9] ^ d[8:0];
   endfunction

   logic [17:0] r2 [10];
   logic [17:0] u3 [6];
   logic [17:0] s4 [5];

   initial begin
      logic [15:0] exp_id;
      logic [8:0]  c;
      int          n;

      r2 = '{18'h00010, 18'h2AAAA, 18'h15555, 18'h3FE00, 18'h001FF,
             18'h12345, 18'h0ABCD, 18'h3C3C3, 18'h00100, 18'h20000};
      u3 = '{18'h00003, 18'h30000, 18'h1F00F, 18'h00A5A, 18'h3FFFE, 18'h05050};
      s4 = '{18'h11111, 18'h22222, 18'h33333, 18'h0F0F0, 18'h30303};

      // Reset held with a non-empty memory and tx_enable high.
      sys_reset = 1'b1;
      tx_enable = 1'b1;
      push(18'h00001);
      push(18'h3FFFF);
      push(18'h00F0F);
      repeat (2) @(negedge clk3);
      check("rst_lvds", 32'(LVDS), 32'(IDLE_W));
      check("rst_valid", 32'(lvds_valid), 32'd0);
      check("rst_rd_en", 32'(mem_rd_en), 32'd0);
      check("rst_frame_id", 32'(frame_id), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      // Basic 3-record frame; words hand-computed.
      sys_reset = 1'b0;
      step("f1_hdr", 24'h400000, 1'b1);
      check("f1_busy", 32'(busy), 32'd1);
      step("f1_d0", 24'h800001, 1'b1);
      step("f1_d1", 24'h87FFFF, 1'b1);
      step("f1_d2", 24'h880F0F, 1'b1);
      step("f1_trl", 24'hE12003, 1'b1);
      step("f1_gap0", IDLE_W, 1'b0);
      check("f1_frame_id", 32'(frame_id), 32'd1);
      step("f1_gap1", IDLE_W, 1'b0);
      exp_id = 16'd1;

      // MAX_HITS=4 with 10 records: frames of 4, 4, then 2 (memory runs dry).
      for (int i = 0; i < 10; i++) push(r2[i]);
      for (int f = 0; f < 3; f++) begin
         n = (f < 2) ? 4 : 2;
         c = 9'd0;
         step("mh_hdr", hdr(exp_id), 1'b1);
         for (int k = 0; k < n; k++) begin
            step("mh_data", dat(4'(k), r2[4*f+k]), 1'b1);
            c = c ^ fold(r2[4*f+k]);
            if (f == 0 && k == 2) check("mh_limit_rd_en", 32'(mem_rd_en), 32'd0);
         end
         step("mh_trl", trl(c, 13'(n)), 1'b1);
         step("mh_gap0", IDLE_W, 1'b0);
         step("mh_gap1", IDLE_W, 1'b0);
         exp_id = exp_id + 16'd1;
      end
      check("mh_frame_id", 32'(frame_id), 32'(exp_id));

      // tx_enable dropped after HEADER: frame completes, then no new frame.
      for (int i = 0; i < 6; i++) push(u3[i]);
      step("tx_hdr", hdr(exp_id), 1'b1);
      tx_enable = 1'b0;
      c = 9'd0;
      for (int k = 0; k < 4; k++) begin
         step("tx_data", dat(4'(k), u3[k]), 1'b1);
         c = c ^ fold(u3[k]);
      end
      step("tx_trl", trl(c, 13'd4), 1'b1);
      step("tx_gap0", IDLE_W, 1'b0);
      step("tx_gap1", IDLE_W, 1'b0);
      exp_id = exp_id + 16'd1;
      for (int k = 0; k < 3; k++) step("tx_hold", IDLE_W, 1'b0);
      check("tx_hold_busy", 32'(busy), 32'd0);
      check("tx_hold_rd_en", 32'(mem_rd_en), 32'd0);
      tx_enable = 1'b1;
      step("tx2_hdr", hdr(exp_id), 1'b1);
      tx_enable = 1'b0;
      step("tx2_d0", dat(4'd0, u3[4]), 1'b1);
      step("tx2_d1", dat(4'd1, u3[5]), 1'b1);
      step("tx2_trl", trl(fold(u3[4]) ^ fold(u3[5]), 13'd2), 1'b1);
      step("tx2_gap0", IDLE_W, 1'b0);
      step("tx2_gap1", IDLE_W, 1'b0);

      // Reset pulsed mid-DATA: frame abandoned, next frame restarts cleanly.
      tx_enable = 1'b1;
      for (int i = 0; i < 5; i++) push(s4[i]);
      step("mr_hdr", hdr(exp_id + 16'd1), 1'b1);
      step("mr_d0", dat(4'd0, s4[0]), 1'b1);
      step("mr_d1", dat(4'd1, s4[1]), 1'b1);
      sys_reset = 1'b1;
      tx_enable = 1'b0;
      #1;
      check("mr_async_lvds", 32'(LVDS), 32'(IDLE_W));
      check("mr_async_valid", 32'(lvds_valid), 32'd0);
      check("mr_async_rd_en", 32'(mem_rd_en), 32'd0);
      check("mr_async_busy", 32'(busy), 32'd0);
      check("mr_async_frame_id", 32'(frame_id), 32'd0);
      step("mr_hold", IDLE_W, 1'b0);
      sys_reset = 1'b0;
      tx_enable = 1'b1;
      step("mr2_hdr", 24'h400000, 1'b1);
      step("mr2_d0", dat(4'd0, s4[3]), 1'b1);
      step("mr2_d1", dat(4'd1, s4[4]), 1'b1);
      step("mr2_trl", trl(fold(s4[3]) ^ fold(s4[4]), 13'd2), 1'b1);
      step("mr2_gap0", IDLE_W, 1'b0);
      step("mr2_gap1", IDLE_W, 1'b0);
      check("mr2_frame_id", 32'(frame_id), 32'd1);

      // frame_id wrap from 16'hFFFF to 0.
      tx_enable = 1'b0;
      force dut.frame_id_q = 16'hFFFF;
      @(negedge clk3);
      release dut.frame_id_q;
      #1;
      check("wrap_preload", 32'(frame_id), 32'h0000FFFF);
      push(18'h2BCDE);
      tx_enable = 1'b1;
      step("wrap_hdr", 24'h40FFFF, 1'b1);
      step("wrap_d0", dat(4'd0, 18'h2BCDE), 1'b1);
      step("wrap_trl", trl(fold(18'h2BCDE), 13'd1), 1'b1);
      step("wrap_gap0", IDLE_W, 1'b0);
      check("wrap_frame_id", 32'(frame_id), 32'd0);
      step("wrap_gap1", IDLE_W, 1'b0);
      push(18'h00777);
      step("wrap2_hdr", 24'h400000, 1'b1);
      step("wrap2_d0", dat(4'd0, 18'h00777), 1'b1);
      step("wrap2_trl", trl(fold(18'h00777), 13'd1), 1'b1);
      step("wrap2_gap0", IDLE_W, 1'b0);
      step("wrap2_gap1", IDLE_W, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
